alu_writeback: RTL and testbench

Writeback/retire stage directly downstream of the 16-bit ALU. Buffers each ALU result and its N/Z/C/V condition codes with destination and control fields in a small in-order FIFO. Retires entries to the register-file write port when the register file is ready, maintains the architectural flag register, and resolves conditional branches against it. A taken branch flushes younger entries.

---
 rtl/cpu16_pkg.sv | 44 ++++
 rtl/br_cond_eval.sv | 40 ++++
 rtl/alu_writeback.sv | 132 +++++++++++++
 tb/tb_alu_writeback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: branch condition encodings, flag bit positions and
// the writeback FIFO entry layout.
package cpu16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned COND_W = 4;
  // rd field is sized for the widest supported register file; narrower files zero-extend.
  localparam int unsigned RD_W   = 8;

  localparam logic [COND_W-1:0] COND_AL = 4'd0;
  localparam logic [COND_W-1:0] COND_EQ = 4'd1;
  localparam logic [COND_W-1:0] COND_NE = 4'd2;
  localparam logic [COND_W-1:0] COND_CS = 4'd3;
  localparam logic [COND_W-1:0] COND_CC = 4'd4;
  localparam logic [COND_W-1:0] COND_MI = 4'd5;
  localparam logic [COND_W-1:0] COND_PL = 4'd6;
  localparam logic [COND_W-1:0] COND_VS = 4'd7;
  localparam logic [COND_W-1:0] COND_VC = 4'd8;
  localparam logic [COND_W-1:0] COND_HI = 4'd9;
  localparam logic [COND_W-1:0] COND_LS = 4'd10;
  localparam logic [COND_W-1:0] COND_GE = 4'd11;
  localparam logic [COND_W-1:0] COND_LT = 4'd12;
  localparam logic [COND_W-1:0] COND_GT = 4'd13;
  localparam logic [COND_W-1:0] COND_LE = 4'd14;
  localparam logic [COND_W-1:0] COND_NV = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [CC_W-1:0]   cc;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic              setcc;
    logic              br;
    logic [COND_W-1:0] cond;
    logic [DATA_W-1:0] target;
  } wb_entry_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator over the {N,Z,C,V} flag register.
module br_cond_eval
  import cpu16_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       take
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    take = 1'b0;
    unique case (cond)
      COND_AL: take = 1'b1;
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_MI: take = n;
      COND_PL: take = !n;
      COND_VS: take = v;
      COND_VC: take = !v;
      COND_HI: take = c && !z;
      COND_LS: take = !c || z;
      COND_GE: take = (n == v);
      COND_LT: take = (n != v);
      COND_GT: take = !z && (n == v);
      COND_LE: take = z || (n != v);
      COND_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback/retire stage: in-order FIFO of ALU results, flag register, branch resolve and flush.
// Optional WB_BYPASS_EN: an entry arriving at an empty FIFO retires in the same cycle.
module alu_writeback
  import cpu16_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [3:0]       in_cc,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_wen,
  input  logic             in_setcc,
  input  logic             in_br,
  input  logic [3:0]       in_cond,
  input  logic [15:0]      in_target,
  input  logic             rf_ready,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [15:0]      rf_wdata,
  output logic [3:0]       flags,
  output logic             br_taken,
  output logic [15:0]      br_target
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       flags_q, flags_d;

  wb_entry_t in_entry;
  wb_entry_t head;
  logic      empty, full, bypass, head_valid;
  logic      retire, pop, push, cond_true, taken;

  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.cc     = in_cc;
    in_entry.rd     = RD_W'(in_rd);
    in_entry.wen    = in_wen;
    in_entry.setcc  = in_setcc;
    in_entry.br     = in_br;
    in_entry.cond   = in_cond;
    in_entry.target = in_target;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full && !reset;

`ifdef WB_BYPASS_EN
  assign bypass = empty && in_valid && rf_ready && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign head       = bypass ? in_entry : mem_q[rd_ptr_q];
  assign head_valid = !empty || bypass;
  // Retire is suppressed during reset so no queued entry leaks out.
  assign retire     = head_valid && rf_ready && !reset;
  assign pop        = retire && !bypass;
  assign push       = in_valid && in_ready && !bypass;

  br_cond_eval u_br_cond_eval (
    .flags (flags_q),
    .cond  (head.cond),
    .take  (cond_true)
  );

  assign taken = retire && head.br && cond_true;

  assign rf_we     = retire && head.wen;
  assign rf_waddr  = retire ? RF_AW'(head.rd) : '0;
  assign rf_wdata  = retire ? head.result : '0;
  assign br_taken  = taken;
  assign br_target = taken ? head.target : '0;
  assign flags     = flags_q;

  generate
    if (RF_AW < RD_W) begin : g_rd_pad
      logic unused_rd_pad;
      assign unused_rd_pad = ^head.rd[RD_W-1:RF_AW];
    end
  endgenerate

  // Next-state for pointers, occupancy and flags; a taken branch empties the FIFO,
  // including any entry pushed in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (retire && head.setcc) flags_d = head.cc;
    if (taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  // Payload storage needs no reset; occupancy alone marks entries valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (default build, DEPTH=2, RF_AW=3).
module tb_alu_writeback;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_cc;
  logic [2:0]  in_rd;
  logic        in_wen;
  logic        in_setcc;
  logic        in_br;
  logic [3:0]  in_cond;
  logic [15:0] in_target;
  logic        rf_ready;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  flags;
  logic        br_taken;
  logic [15:0] br_target;

  int n_checks = 0;
  int n_errors = 0;

  alu_writeback #(.DEPTH(2), .RF_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_cc     (in_cc),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_setcc  (in_setcc),
    .in_br     (in_br),
    .in_cond   (in_cond),
    .in_target (in_target),
    .rf_ready  (rf_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .flags     (flags),
    .br_taken  (br_taken),
    .br_target (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] res, input logic [2:0] rd, input logic wen,
                       input logic setcc, input logic [3:0] cc, input logic br,
                       input logic [3:0] cond, input logic [15:0] tgt);
    in_valid  = 1'b1;
    in_result = res;
    in_rd     = rd;
    in_wen    = wen;
    in_setcc  = setcc;
    in_cc     = cc;
    in_br     = br;
    in_cond   = cond;
    in_target = tgt;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_result = '0;
    in_rd     = '0;
    in_wen    = 1'b0;
    in_setcc  = 1'b0;
    in_cc     = '0;
    in_br     = 1'b0;
    in_cond   = '0;
    in_target = '0;
  endtask

  // Advance one full cycle: pass the rising edge, land on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] cond;
    logic       exp;
  } cvec_t;

  cvec_t cvecs [10];

  initial begin
    cvecs[0] = '{4'b0000, 4'd15, 1'b0};
    cvecs[1] = '{4'b0000, 4'd0,  1'b1};
    cvecs[2] = '{4'b1001, 4'd11, 1'b1};
    cvecs[3] = '{4'b1000, 4'd12, 1'b1};
    cvecs[4] = '{4'b0010, 4'd9,  1'b1};
    cvecs[5] = '{4'b0110, 4'd10, 1'b1};
    cvecs[6] = '{4'b0000, 4'd13, 1'b1};
    cvecs[7] = '{4'b1000, 4'd14, 1'b1};
    cvecs[8] = '{4'b0001, 4'd7,  1'b1};
    cvecs[9] = '{4'b0010, 4'd4,  1'b0};

    idle();
    reset    = 1'b1;
    rf_ready = 1'b0;
    step();
    #1 check("ready_in_reset", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rst_ready",   32'(in_ready),  32'd1);
    check("rst_we",      32'(rf_we),     32'd0);
    check("rst_waddr",   32'(rf_waddr),  32'd0);
    check("rst_wdata",   32'(rf_wdata),  32'd0);
    check("rst_flags",   32'(flags),     32'd0);
    check("rst_brtaken", 32'(br_taken),  32'd0);
    check("rst_brtgt",   32'(br_target), 32'd0);

    // Back-to-back writes with 1-cycle latency
    step();
    rf_ready = 1'b1;
    drive(16'h1234, 3'd3, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1 check("b2b_empty_we", 32'(rf_we), 32'd0);
    step();
    drive(16'hFFFF, 3'd5, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1;
    check("b2b_a_we",    32'(rf_we),    32'd1);
    check("b2b_a_addr",  32'(rf_waddr), 32'd3);
    check("b2b_a_data",  32'(rf_wdata), 32'h1234);
    step();
    idle();
    #1;
    check("b2b_b_we",    32'(rf_we),    32'd1);
    check("b2b_b_addr",  32'(rf_waddr), 32'd5);
    check("b2b_b_data",  32'(rf_wdata), 32'hFFFF);
    step();
    #1 check("b2b_done_we", 32'(rf_we), 32'd0);

    // Backpressure: fill with rf_ready low, third push refused
    rf_ready = 1'b0;
    drive(16'h0011, 3'd1, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1 check("bp_ready0", 32'(in_ready), 32'd1);
    step();
    drive(16'h0022, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1 check("bp_ready1", 32'(in_ready), 32'd1);
    step();
    drive(16'h0033, 3'd6, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_hold_we",    32'(rf_we),    32'd0);
    step();
    idle();
    rf_ready = 1'b1;
    #1;
    check("bp_ready_still0", 32'(in_ready), 32'd0);
    check("bp_r1_addr",      32'(rf_waddr), 32'd1);
    check("bp_r1_data",      32'(rf_wdata), 32'h0011);
    step();
    #1;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_r2_addr",    32'(rf_waddr), 32'd2);
    check("bp_r2_data",    32'(rf_wdata), 32'h0022);
    step();
    #1 check("bp_no_third", 32'(rf_we), 32'd0);

    // Flags then EQ branch
    drive(16'h0, 3'd0, 1'b0, 1'b1, 4'b0100, 1'b0, 4'd0, 16'h0);
    step();
    drive(16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd1, 16'h0040);
    #1;
    check("fb_setcc_we", 32'(rf_we), 32'd0);
    check("fb_flags_pre", 32'(flags), 32'd0);
    step();
    idle();
    #1;
    check("fb_flags",  32'(flags),     32'b0100);
    check("fb_taken",  32'(br_taken),  32'd1);
    check("fb_target", 32'(br_target), 32'h0040);
    step();
    #1 check("fb_pulse_end", 32'(br_taken), 32'd0);

    // Same-entry setcc and branch uses pre-update flags
    drive(16'h0, 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0, 16'h0);
    step();
    drive(16'h0, 3'd0, 1'b0, 1'b1, 4'b0100, 1'b1, 4'd1, 16'h0080);
    step();
    idle();
    #1;
    check("same_flags_pre", 32'(flags),     32'd0);
    check("same_taken",     32'(br_taken),  32'd0);
    check("same_target",    32'(br_target), 32'd0);
    step();
    #1 check("same_flags_post", 32'(flags), 32'b0100);

    // Flush of a queued younger write
    rf_ready = 1'b0;
    drive(16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0, 16'h0100);
    step();
    drive(16'h2222, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    step();
    idle();
    rf_ready = 1'b1;
    #1;
    check("fl_taken",  32'(br_taken),  32'd1);
    check("fl_target", 32'(br_target), 32'h0100);
    check("fl_we",     32'(rf_we),     32'd0);
    step();
    #1;
    check("fl_after_we",    32'(rf_we),    32'd0);
    check("fl_after_ready", 32'(in_ready), 32'd1);

    // Flush of an entry pushed in the taken-branch cycle
    rf_ready = 1'b0;
    drive(16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0, 16'h0200);
    step();
    rf_ready = 1'b1;
    drive(16'h4444, 3'd4, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    #1;
    check("fl2_taken", 32'(br_taken), 32'd1);
    check("fl2_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    #1 check("fl2_dropped_we", 32'(rf_we), 32'd0);
    step();
    #1 check("fl2_empty_we", 32'(rf_we), 32'd0);

    // Reset with two entries queued
    rf_ready = 1'b0;
    drive(16'h6666, 3'd6, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    step();
    drive(16'h7777, 3'd7, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 16'h0);
    step();
    idle();
    reset    = 1'b1;
    rf_ready = 1'b1;
    #1;
    check("mr_ready_rst", 32'(in_ready), 32'd0);
    check("mr_we_rst",    32'(rf_we),    32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mr_flags", 32'(flags),    32'd0);
    check("mr_we",    32'(rf_we),    32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    step();
    #1 check("mr_no_stale", 32'(rf_we), 32'd0);

    // Condition code table
    for (int i = 0; i < 10; i++) begin
      drive(16'h0, 3'd0, 1'b0, 1'b1, cvecs[i].f, 1'b0, 4'd0, 16'h0);
      step();
      drive(16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b1, cvecs[i].cond, 16'h1000 + 16'(i));
      step();
      idle();
      #1;
      check($sformatf("cond%0d_taken", cvecs[i].cond), 32'(br_taken), 32'(cvecs[i].exp));
      check($sformatf("cond%0d_tgt", cvecs[i].cond), 32'(br_target),
            cvecs[i].exp ? 32'h1000 + 32'(i) : 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
